// File: rtl/cpu_run_pkg.sv
// Shared types for the multicycle CPU run controller: run FSM states,
// trace FIFO entry layout and the TOHOST pass value.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } run_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/run_trace_fifo.sv
// Synchronous FIFO of CPU store trace entries; a pop frees the slot that a
// same-cycle push uses, so push+pop is accepted even when full.
module run_trace_fifo
    import cpu_run_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  trace_entry_t push_entry,
    input  logic         pop,
    output trace_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_entry_t   mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra MSB on each pointer tells a full ring from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the multicycle MIPS CPU: clock-enable divider, CPU reset
// sequencing, TOHOST pass/fail snooping, cycle watchdog and a store trace FIFO.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 1,
    parameter int unsigned RST_CYCLES  = 4,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFFC,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             start,
    output logic             clk_en,
    output logic             cpu_rst,
    input  logic             wr_en,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      w_data,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [31:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_data,
    output logic             trace_overflow
);

    localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned      RST_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    run_state_t       state;
    run_state_t       state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] count_inc;
    logic             active;
    logic             start_ok;
    logic             store;
    logic             tohost_hit;
    logic             timeout_hit;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    trace_entry_t     fifo_head;
    trace_entry_t     store_entry;

    assign active      = (state == RESET) || (state == RUN);
    assign clk_en      = active && (div_cnt == DIV_LAST);
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign store       = clk_en && wr_en && (state == RUN);
    assign tohost_hit  = store && (mem_addr == TOHOST_ADDR);
    assign count_inc   = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    // A TOHOST store on the same pulse as the watchdog expiry takes priority.
    assign timeout_hit = (state == RUN) && clk_en && !tohost_hit && (count_inc >= TIMEOUT_C);

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_rst    = 1'b0;
        running    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cpu_rst = 1'b1;
                if (start) begin
                    state_next = RESET;
                end
            end
            RESET: begin
                cpu_rst = 1'b1;
                running = 1'b1;
                if (clk_en && (rst_cnt == RST_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                running = 1'b1;
                if (tohost_hit || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RESET;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            div_cnt        <= '0;
            rst_cnt        <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_code      <= '0;
            cycle_count    <= '0;
            trace_overflow <= 1'b0;
        end else if (start_ok) begin
            div_cnt        <= '0;
            rst_cnt        <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_code      <= '0;
            cycle_count    <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (active) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
            if ((state == RESET) && clk_en) begin
                rst_cnt <= rst_cnt + RST_W'(1);
            end
            if ((state == RUN) && clk_en) begin
                cycle_count <= count_inc;
            end
            if (tohost_hit) begin
                pass      <= (w_data == TOHOST_PASS);
                fail_code <= (w_data == TOHOST_PASS) ? '0 : w_data;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
            if (store && fifo_full && !fifo_pop) begin
                trace_overflow <= 1'b1;
            end
        end
    end

    assign fifo_pop    = trace_ready && !fifo_empty;
    assign store_entry = '{addr: mem_addr, data: w_data};

    run_trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk        (clk_100M),
        .rst_n      (rst_n),
        .flush      (start_ok),
        .push       (store),
        .push_entry (store_entry),
        .pop        (trace_ready),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign trace_valid = !fifo_empty;
    assign trace_addr  = fifo_head.addr;
    assign trace_data  = fifo_head.data;

endmodule
